// File: rtl/byte_stream_framer.sv
// Pulls bytes from an FWFT byte FIFO into a frame buffer and transmits each frame
// to a ready/valid byte sink as SOF, LEN, payload, CHK (8-bit payload sum).
module byte_stream_framer #(
  parameter int          MAX_LEN = 64,
  parameter int          TIMEOUT = 1000,
  parameter logic [7:0]  SOF     = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FIFO_EMPTY,
  input  logic [7:0]  FIFO_DATA,
  output logic        FIFO_READ,
  input  logic        TX_READY,
  output logic        TX_VALID,
  output logic [7:0]  TX_DATA,
  output logic        BUSY,
  output logic [15:0] FRAME_CNT
);

  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]        MAX_FILL  = 8'(MAX_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    COLLECT,
    SEND_SOF,
    SEND_LEN,
    SEND_PAY,
    SEND_CHK
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         fill_q, fill_d;
  logic [7:0]         rd_ptr_q, rd_ptr_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [7:0]         sum_q, sum_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic [7:0]         mem_q [MAX_LEN];
  logic               mem_we;
  logic               pop;
  logic               accept;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    rd_ptr_d    = rd_ptr_q;
    idle_d      = idle_q;
    sum_d       = sum_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;
    mem_we      = 1'b0;
    pop         = 1'b0;
    accept      = tx_valid_q && TX_READY;

    case (state_q)
      COLLECT: begin
        pop = !RST && !FIFO_EMPTY && (fill_q < MAX_FILL);
        if (pop) begin
          mem_we = 1'b1;
          fill_d = fill_q + 8'd1;
          sum_d  = sum_q + FIFO_DATA;
          idle_d = '0;
        end else if (fill_q != 8'd0) begin
          // A pop always wins over the idle timeout, so closing is only decided here.
          if ((fill_q == MAX_FILL) || (idle_q == IDLE_LAST)) begin
            state_d    = SEND_SOF;
            tx_data_d  = SOF;
            tx_valid_d = 1'b1;
            idle_d     = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end else begin
          idle_d = '0;
        end
      end
      SEND_SOF: begin
        if (accept) begin
          tx_data_d = fill_q;
          state_d   = SEND_LEN;
        end
      end
      SEND_LEN: begin
        if (accept) begin
          tx_data_d = mem_q[0];
          rd_ptr_d  = 8'd1;
          state_d   = SEND_PAY;
        end
      end
      SEND_PAY: begin
        if (accept) begin
          if (rd_ptr_q == fill_q) begin
            tx_data_d = sum_q;
            state_d   = SEND_CHK;
          end else begin
            tx_data_d = mem_q[rd_ptr_q[IDX_W-1:0]];
            rd_ptr_d  = rd_ptr_q + 8'd1;
          end
        end
      end
      SEND_CHK: begin
        if (accept) begin
          tx_valid_d  = 1'b0;
          fill_d      = 8'd0;
          sum_d       = 8'd0;
          idle_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= COLLECT;
      fill_q      <= 8'd0;
      rd_ptr_q    <= 8'd0;
      idle_q      <= '0;
      sum_q       <= 8'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      rd_ptr_q    <= rd_ptr_d;
      idle_q      <= idle_d;
      sum_q       <= sum_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Payload storage needs no reset: only indices below fill are ever read.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[fill_q[IDX_W-1:0]] <= FIFO_DATA;
    end
  end

  assign FIFO_READ = pop;
  assign TX_VALID  = tx_valid_q;
  assign TX_DATA   = tx_data_q;
  assign FRAME_CNT = frame_cnt_q;
  assign BUSY      = (state_q != COLLECT) || (fill_q != 8'd0);

endmodule

// File: tb/tb_byte_stream_framer.sv
// Directed bench for byte_stream_framer: FWFT source model, frame scoreboard,
// back-pressure stability and timing checks.
module tb_byte_stream_framer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_EMPTY = 1'b1;
  logic [7:0]  FIFO_DATA = 8'h00;
  logic        FIFO_READ;
  logic        TX_READY = 1'b1;
  logic        TX_VALID;
  logic [7:0]  TX_DATA;
  logic        BUSY;
  logic [15:0] FRAME_CNT;

  byte_stream_framer #(.MAX_LEN(4), .TIMEOUT(16), .SOF(8'hA5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_READ  (FIFO_READ),
    .TX_READY   (TX_READY),
    .TX_VALID   (TX_VALID),
    .TX_DATA    (TX_DATA),
    .BUSY       (BUSY),
    .FRAME_CNT  (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  bit rdy_rand = 1'b0;
  bit hold_pend = 1'b0;
  logic [7:0] held = 8'h00;
  bit prev_valid = 1'b0;
  int sof_cyc = 0;
  int last_pop_cyc = 0;
  int acc_cnt = 0;
  int exp_frames = 0;
  int rd_seen = 0;
  int v_seen = 0;
  int b_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_src();
    FIFO_EMPTY = (src_q.size() == 0);
    FIFO_DATA  = FIFO_EMPTY ? 8'h00 : src_q[0];
  endtask

  task automatic add_byte(input logic [7:0] b);
    src_q.push_back(b);
    pay_q.push_back(b);
    drive_src();
  endtask

  // Golden frame: SOF, LEN, payload, mod-256 sum.
  task automatic close_exp();
    logic [7:0] s;
    s = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(pay_q.size()));
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      s = s + pay_q[i];
    end
    exp_q.push_back(s);
    pay_q.delete();
    exp_frames++;
  endtask

  task automatic tick();
    bit pop;
    @(negedge CLK);
    if (FIFO_READ) rd_seen++;
    if (TX_VALID) v_seen++;
    if (BUSY) b_seen++;
    if (RST) begin
      chk("fifo_read_in_reset", 32'(FIFO_READ), 32'd0);
    end else begin
      if (TX_VALID) chk("no_pop_while_tx", 32'(FIFO_READ), 32'd0);
      if (hold_pend) begin
        chk("hold_valid", 32'(TX_VALID), 32'd1);
        chk("hold_data", 32'(TX_DATA), 32'(held));
      end
      if (TX_VALID && !prev_valid) sof_cyc = cyc;
      if (TX_VALID && TX_READY) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_byte observed=%0h expected=none", TX_DATA);
        end else begin
          chk("stream_byte", 32'(TX_DATA), 32'(exp_q.pop_front()));
        end
      end
    end
    hold_pend  = !RST && TX_VALID && !TX_READY;
    held       = TX_DATA;
    prev_valid = !RST && TX_VALID;
    pop = FIFO_READ;
    if (pop) last_pop_cyc = cyc + 1;
    @(posedge CLK);
    cyc++;
    #1;
    if (pop && src_q.size() > 0) void'(src_q.pop_front());
    drive_src();
    if (rdy_rand) TX_READY = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout observed=%0d_bytes_left expected=0", tag, exp_q.size());
      exp_q.delete();
    end
    chk({tag, "_frame_cnt"}, 32'(FRAME_CNT), 32'(exp_frames[15:0]));
    chk({tag, "_valid_low"}, 32'(TX_VALID), 32'd0);
  endtask

  initial begin
    int n;
    int len;
    RST = 1'b1;
    TX_READY = 1'b1;
    drive_src();
    repeat (3) tick();
    chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("rst_tx_data", 32'(TX_DATA), 32'd0);
    chk("rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    tick();

    // Timeout close of a partial frame
    add_byte(8'h01); add_byte(8'h02); add_byte(8'h03);
    close_exp();
    wait_done("t1", 200);
    chk("t1_timeout_gap", 32'(sof_cyc - last_pop_cyc), 32'd16);

    // Full close, then remainder closes on timeout
    add_byte(8'h10); add_byte(8'h11); add_byte(8'h12); add_byte(8'h13);
    close_exp();
    add_byte(8'h14); add_byte(8'h15);
    close_exp();
    wait_done("t2", 300);
    chk("t2_timeout_gap", 32'(sof_cyc - last_pop_cyc), 32'd16);

    // Checksum wraps mod 256
    add_byte(8'hFF); add_byte(8'hFF); add_byte(8'h03);
    close_exp();
    wait_done("t3", 200);

    // Random back-pressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) add_byte(8'($urandom_range(0, 255)));
      close_exp();
      wait_done("t4", 400);
    end
    rdy_rand = 1'b0;
    TX_READY = 1'b1;
    tick();

    // Reset during payload transmission
    add_byte(8'h21); add_byte(8'h22); add_byte(8'h23); add_byte(8'h24);
    close_exp();
    acc_cnt = 0;
    n = 0;
    while (acc_cnt < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_in_payload", 32'(acc_cnt), 32'd3);
    chk("t5_valid_before_rst", 32'(TX_VALID), 32'd1);
    RST = 1'b1;
    exp_q.delete();
    src_q.delete();
    pay_q.delete();
    exp_frames = 0;
    add_byte(8'h77); add_byte(8'h88);
    tick();
    chk("t5_valid_after_rst", 32'(TX_VALID), 32'd0);
    chk("t5_cnt_after_rst", 32'(FRAME_CNT), 32'd0);
    tick();
    RST = 1'b0;
    close_exp();
    wait_done("t5", 200);

    // Long empty source: nothing should happen
    rd_seen = 0;
    v_seen = 0;
    b_seen = 0;
    repeat (5000) tick();
    chk("t6_no_read", 32'(rd_seen), 32'd0);
    chk("t6_no_valid", 32'(v_seen), 32'd0);
    chk("t6_not_busy", 32'(b_seen), 32'd0);
    chk("t6_frame_cnt", 32'(FRAME_CNT), 32'(exp_frames[15:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
